// File: rtl/l2_width_bridge_buffer_if.sv
// l2_width_bridge_buffer_if: L1/DDR port bundle with control and status for the width bridge buffer
interface l2_width_bridge_buffer_if #(
  parameter int NARROW_W   = 16,
  parameter int RATIO      = 8,
  parameter int WIDE_DEPTH = 512
);
  localparam int WW = NARROW_W * RATIO;
  localparam int NA = $clog2(WIDE_DEPTH * RATIO);
  logic                i_mode;
  logic                i_flush;
  logic                i_clr_err;
  logic                i_l1_wr_en;
  logic [NARROW_W-1:0] i_l1_wr_data;
  logic                i_l1_rd_en;
  logic [NARROW_W-1:0] o_l1_rd_data;
  logic                o_l1_rd_valid;
  logic                i_ddr_wr_en;
  logic [WW-1:0]       i_ddr_wr_data;
  logic                i_ddr_rd_en;
  logic [WW-1:0]       o_ddr_rd_data;
  logic                o_ddr_rd_valid;
  logic [NA:0]         o_count;
  logic                o_empty;
  logic                o_full;
  logic                o_aempty;
  logic                o_afull;
  logic                o_mode;
  logic                o_err_ovf;
  logic                o_err_udf;
  logic                o_err_mode;
  modport master (
    output i_mode, i_flush, i_clr_err, i_l1_wr_en, i_l1_wr_data, i_l1_rd_en,
           i_ddr_wr_en, i_ddr_wr_data, i_ddr_rd_en,
    input  o_l1_rd_data, o_l1_rd_valid, o_ddr_rd_data, o_ddr_rd_valid, o_count,
           o_empty, o_full, o_aempty, o_afull, o_mode, o_err_ovf, o_err_udf, o_err_mode
  );
  modport slave (
    input  i_mode, i_flush, i_clr_err, i_l1_wr_en, i_l1_wr_data, i_l1_rd_en,
           i_ddr_wr_en, i_ddr_wr_data, i_ddr_rd_en,
    output o_l1_rd_data, o_l1_rd_valid, o_ddr_rd_data, o_ddr_rd_valid, o_count,
           o_empty, o_full, o_aempty, o_afull, o_mode, o_err_ovf, o_err_udf, o_err_mode
  );
endinterface

// File: rtl/l2_width_bridge_buffer.sv
// l2_width_bridge_buffer: run-time direction asymmetric-width circular buffer between L1 and DDR
module l2_width_bridge_buffer #(
  parameter int NARROW_W   = 16,
  parameter int RATIO      = 8,
  parameter int WIDE_DEPTH = 512,
  parameter int AFULL_TH   = WIDE_DEPTH * RATIO - RATIO,
  parameter int AEMPTY_TH  = RATIO
) (
  input logic                       clk_166M66,
  input logic                       mcu_sys_rst_n,
  l2_width_bridge_buffer_if.slave   bus
);
  localparam int WW  = NARROW_W * RATIO;
  localparam int CAP = WIDE_DEPTH * RATIO;
  localparam int NA  = $clog2(CAP);
  localparam int LR  = $clog2(RATIO);
  localparam logic [NA:0] CAP_C = (NA + 1)'(CAP);
  localparam logic [NA:0] RAT_C = (NA + 1)'(RATIO);
  localparam logic [NA:0] AF_C  = (NA + 1)'(AFULL_TH);
  localparam logic [NA:0] AE_C  = (NA + 1)'(AEMPTY_TH);
  logic [NARROW_W-1:0] mem [CAP];
  logic [NA-1:0]       wptr, rptr;
  logic [NA:0]         count, count_nx;
  logic [WW-1:0]       wide_q;
  logic                mode, fill, go, any_ok;
  logic                ddr_wr_ok, l1_rd_ok, l1_wr_ok, ddr_rd_ok;
  logic                ovf, udf, mode_err;
  assign fill      = ~mode;
  assign go        = ~bus.i_flush;
  assign ddr_wr_ok = go & fill & bus.i_ddr_wr_en & (count <= CAP_C - RAT_C);
  assign l1_rd_ok  = go & fill & bus.i_l1_rd_en & (count != '0);
  assign l1_wr_ok  = go & ~fill & bus.i_l1_wr_en & (count != CAP_C);
  assign ddr_rd_ok = go & ~fill & bus.i_ddr_rd_en & (count >= RAT_C);
  assign any_ok    = ddr_wr_ok | l1_rd_ok | l1_wr_ok | ddr_rd_ok;
  assign ovf       = go & (fill ? bus.i_ddr_wr_en : bus.i_l1_wr_en) & ~(ddr_wr_ok | l1_wr_ok);
  assign udf       = go & (fill ? bus.i_l1_rd_en : bus.i_ddr_rd_en) & ~(l1_rd_ok | ddr_rd_ok);
  assign mode_err  = go & (fill ? (bus.i_l1_wr_en | bus.i_ddr_rd_en) : (bus.i_ddr_wr_en | bus.i_l1_rd_en));
  assign count_nx  = count + (ddr_wr_ok ? RAT_C : '0) + {{NA{1'b0}}, l1_wr_ok}
                           - (ddr_rd_ok ? RAT_C : '0) - {{NA{1'b0}}, l1_rd_ok};
  assign bus.o_count  = count;
  assign bus.o_empty  = count == '0;
  assign bus.o_full   = count == CAP_C;
  assign bus.o_aempty = count <= AE_C;
  assign bus.o_afull  = count >= AF_C;
  assign bus.o_mode   = mode;
  always_comb begin
    wide_q = '0;
    for (int k = 0; k < RATIO; k++) wide_q[k*NARROW_W +: NARROW_W] = mem[{rptr[NA-1:LR], LR'(k)}];
  end
  always_ff @(posedge clk_166M66) begin
    if (l1_wr_ok) mem[wptr] <= bus.i_l1_wr_data;
    if (ddr_wr_ok)
      for (int k = 0; k < RATIO; k++) mem[{wptr[NA-1:LR], LR'(k)}] <= bus.i_ddr_wr_data[k*NARROW_W +: NARROW_W];
  end
  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      wptr               <= '0;
      rptr               <= '0;
      count              <= '0;
      mode               <= 1'b0;
      bus.o_l1_rd_valid  <= 1'b0;
      bus.o_l1_rd_data   <= '0;
      bus.o_ddr_rd_valid <= 1'b0;
      bus.o_ddr_rd_data  <= '0;
      bus.o_err_ovf      <= 1'b0;
      bus.o_err_udf      <= 1'b0;
      bus.o_err_mode     <= 1'b0;
    end else begin
      count              <= bus.i_flush ? '0 : count_nx;
      wptr               <= bus.i_flush ? '0 : l1_wr_ok ? wptr + NA'(1) :
                            ddr_wr_ok ? {wptr[NA-1:LR] + (NA - LR)'(1), {LR{1'b0}}} : wptr;
      rptr               <= bus.i_flush ? '0 : l1_rd_ok ? rptr + NA'(1) :
                            ddr_rd_ok ? {rptr[NA-1:LR] + (NA - LR)'(1), {LR{1'b0}}} : rptr;
      mode               <= (bus.i_flush | ((count == '0) & ~any_ok)) ? bus.i_mode : mode;
      bus.o_l1_rd_valid  <= l1_rd_ok;
      bus.o_l1_rd_data   <= l1_rd_ok ? mem[rptr] : bus.o_l1_rd_data;
      bus.o_ddr_rd_valid <= ddr_rd_ok;
      bus.o_ddr_rd_data  <= ddr_rd_ok ? wide_q : bus.o_ddr_rd_data;
      bus.o_err_ovf      <= ovf | (bus.o_err_ovf & ~bus.i_clr_err);
      bus.o_err_udf      <= udf | (bus.o_err_udf & ~bus.i_clr_err);
      bus.o_err_mode     <= mode_err | (bus.o_err_mode & ~bus.i_clr_err);
    end
  end
endmodule

// File: tb/tb_l2_width_bridge_buffer.sv
// tb_l2_width_bridge_buffer: directed table and sequence checks for l2_width_bridge_buffer
module tb_l2_width_bridge_buffer;
  localparam int NW = 16;
  localparam int RATIO = 8;
  localparam int WD = 512;
  localparam int CAP = WD * RATIO;
  typedef struct packed {
    logic         md;
    logic         fl;
    logic         cl;
    logic         rd;
    logic         dwr;
    logic [127:0] wd;
    logic         drd;
    logic [12:0]  cnt;
    logic         l1v;
    logic [15:0]  l1d;
    logic         om;
    logic [2:0]   err;
  } vec_t;
  logic clk_166M66 = 1'b0;
  logic mcu_sys_rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  vec_t tv [$];
  l2_width_bridge_buffer_if #(.NARROW_W(NW), .RATIO(RATIO), .WIDE_DEPTH(WD)) bus ();
  l2_width_bridge_buffer #(.NARROW_W(NW), .RATIO(RATIO), .WIDE_DEPTH(WD)) dut (
    .clk_166M66(clk_166M66),
    .mcu_sys_rst_n(mcu_sys_rst_n),
    .bus(bus)
  );
  always #5 clk_166M66 = ~clk_166M66;
  function automatic logic [127:0] wide_of(input int base);
    logic [127:0] w;
    for (int k = 0; k < RATIO; k++) w[k*NW +: NW] = 16'(base + k);
    return w;
  endfunction
  function automatic vec_t mk(input int md, fl, cl, rd, dwr, input logic [127:0] wd,
                              input int drd, cnt, l1v, l1d, om, err);
    vec_t v;
    v.md = 1'(md); v.fl = 1'(fl); v.cl = 1'(cl); v.rd = 1'(rd); v.dwr = 1'(dwr);
    v.wd = wd; v.drd = 1'(drd); v.cnt = 13'(cnt); v.l1v = 1'(l1v);
    v.l1d = 16'(l1d); v.om = 1'(om); v.err = 3'(err);
    return v;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic clr_in();
    bus.i_flush = 1'b0; bus.i_clr_err = 1'b0;
    bus.i_l1_wr_en = 1'b0; bus.i_l1_wr_data = '0; bus.i_l1_rd_en = 1'b0;
    bus.i_ddr_wr_en = 1'b0; bus.i_ddr_wr_data = '0; bus.i_ddr_rd_en = 1'b0;
  endtask
  task automatic step();
    @(posedge clk_166M66);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " count"}, int'(bus.o_count), 0);
    chk({tag, " empty"}, int'(bus.o_empty), 1);
    chk({tag, " aempty"}, int'(bus.o_aempty), 1);
    chk({tag, " full"}, int'(bus.o_full), 0);
    chk({tag, " afull"}, int'(bus.o_afull), 0);
    chk({tag, " mode"}, int'(bus.o_mode), 0);
    chk({tag, " l1_valid"}, int'(bus.o_l1_rd_valid), 0);
    chk({tag, " l1_data"}, int'(bus.o_l1_rd_data), 0);
    chk({tag, " ddr_valid"}, int'(bus.o_ddr_rd_valid), 0);
    chkw({tag, " ddr_data"}, bus.o_ddr_rd_data, '0);
    chk({tag, " errs"}, int'({bus.o_err_ovf, bus.o_err_udf, bus.o_err_mode}), 0);
  endtask
  initial begin
    clr_in();
    bus.i_mode = 1'b0;
    repeat (2) @(posedge clk_166M66);
    #1;
    chk_reset("reset");
    mcu_sys_rst_n = 1'b1;
    tv.push_back(mk(0, 0, 0, 0, 1, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 0, 8, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) tv.push_back(mk(0, 0, 0, 1, 0, '0, 0, 7 - k, 1, k, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, '0, 0, 0, 0, 'h7, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, '0, 0, 0, 0, 'h7, 0, 'b010));
    tv.push_back(mk(0, 0, 0, 0, 0, '0, 1, 0, 0, 'h7, 0, 'b011));
    tv.push_back(mk(0, 0, 1, 0, 0, '0, 0, 0, 0, 'h7, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, wide_of('h10), 0, 8, 0, 'h7, 0, 0));
    for (int k = 0; k < 4; k++) tv.push_back(mk(0, 0, 0, 1, 0, '0, 0, 7 - k, 1, 'h10 + k, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, wide_of('h20), 0, 11, 1, 'h14, 0, 0));
    for (int k = 0; k < 8; k++)
      tv.push_back(mk(0, 0, 0, 1, 0, '0, 0, 10 - k, 1, k < 3 ? 'h15 + k : 'h20 + k - 3, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, '0, 0, 3, 0, 'h24, 0, 0));
    tv.push_back(mk(1, 1, 0, 1, 0, '0, 0, 0, 0, 'h24, 1, 0));
    tv.push_back(mk(1, 0, 0, 1, 0, '0, 0, 0, 0, 'h24, 1, 'b001));
    tv.push_back(mk(1, 0, 1, 0, 0, '0, 0, 0, 0, 'h24, 1, 0));
    tv.push_back(mk(1, 0, 1, 0, 0, '0, 1, 0, 0, 'h24, 1, 'b010));
    tv.push_back(mk(1, 0, 1, 0, 0, '0, 0, 0, 0, 'h24, 1, 0));
    foreach (tv[i]) begin
      bus.i_mode = tv[i].md; bus.i_flush = tv[i].fl; bus.i_clr_err = tv[i].cl;
      bus.i_l1_rd_en = tv[i].rd; bus.i_ddr_wr_en = tv[i].dwr;
      bus.i_ddr_wr_data = tv[i].wd; bus.i_ddr_rd_en = tv[i].drd;
      step();
      chk($sformatf("v%0d count", i), int'(bus.o_count), int'(tv[i].cnt));
      chk($sformatf("v%0d empty", i), int'(bus.o_empty), int'(tv[i].cnt == 0));
      chk($sformatf("v%0d l1_valid", i), int'(bus.o_l1_rd_valid), int'(tv[i].l1v));
      chk($sformatf("v%0d l1_data", i), int'(bus.o_l1_rd_data), int'(tv[i].l1d));
      chk($sformatf("v%0d ddr_valid", i), int'(bus.o_ddr_rd_valid), 0);
      chk($sformatf("v%0d mode", i), int'(bus.o_mode), int'(tv[i].om));
      chk($sformatf("v%0d errs", i), int'({bus.o_err_ovf, bus.o_err_udf, bus.o_err_mode}), int'(tv[i].err));
    end
    clr_in();
    bus.i_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.i_l1_wr_en = 1'b1; bus.i_l1_wr_data = 16'(16'hA000 + k);
      step();
    end
    bus.i_l1_wr_en = 1'b0;
    chk("pre count", int'(bus.o_count), 8);
    bus.i_ddr_rd_en = 1'b1;
    step();
    bus.i_ddr_rd_en = 1'b0;
    chk("pre ddr_valid", int'(bus.o_ddr_rd_valid), 1);
    chkw("pre ddr_data", bus.o_ddr_rd_data, wide_of('hA000));
    chk("pre count0", int'(bus.o_count), 0);
    for (int n = 1; n <= CAP; n++) begin
      bus.i_l1_wr_en = 1'b1; bus.i_l1_wr_data = 16'(n - 1);
      step();
      chk("drain count", int'(bus.o_count), n);
      chk("drain afull", int'(bus.o_afull), int'(n >= CAP - RATIO));
      chk("drain aempty", int'(bus.o_aempty), int'(n <= RATIO));
      chk("drain full", int'(bus.o_full), int'(n == CAP));
    end
    bus.i_l1_wr_data = 16'hDEAD;
    step();
    bus.i_l1_wr_en = 1'b0;
    chk("ovf count", int'(bus.o_count), CAP);
    chk("ovf flag", int'(bus.o_err_ovf), 1);
    chk("ovf full", int'(bus.o_full), 1);
    bus.i_clr_err = 1'b1;
    step();
    bus.i_clr_err = 1'b0;
    chk("ovf cleared", int'(bus.o_err_ovf), 0);
    bus.i_ddr_rd_en = 1'b1;
    for (int j = 0; j < WD; j++) begin
      step();
      chk("drain ddr_valid", int'(bus.o_ddr_rd_valid), 1);
      chkw("drain ddr_data", bus.o_ddr_rd_data, wide_of(8 * j));
      chk("drain rd count", int'(bus.o_count), CAP - 8 * (j + 1));
    end
    bus.i_ddr_rd_en = 1'b0;
    step();
    chk("drain end valid", int'(bus.o_ddr_rd_valid), 0);
    chk("drain end empty", int'(bus.o_empty), 1);
    chkw("drain data hold", bus.o_ddr_rd_data, wide_of(8 * (WD - 1)));
    chk("drain no udf", int'(bus.o_err_udf), 0);
    bus.i_mode = 1'b0;
    step();
    chk("relatch mode", int'(bus.o_mode), 0);
    bus.i_ddr_wr_en = 1'b1; bus.i_ddr_wr_data = wide_of('h30);
    step();
    bus.i_ddr_wr_en = 1'b0;
    chk("rst pre count", int'(bus.o_count), 8);
    bus.i_l1_rd_en = 1'b1;
    step();
    chk("rst first valid", int'(bus.o_l1_rd_valid), 1);
    chk("rst first data", int'(bus.o_l1_rd_data), 'h30);
    #3;
    mcu_sys_rst_n = 1'b0;
    #1;
    chk_reset("async");
    step();
    chk("rst held valid", int'(bus.o_l1_rd_valid), 0);
    bus.i_l1_rd_en = 1'b0;
    mcu_sys_rst_n = 1'b1;
    step();
    chk("rst post valid", int'(bus.o_l1_rd_valid), 0);
    chk("rst post count", int'(bus.o_count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
